// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving every datapath control input.
// The control word is decoded from the step register plus the opcode latched at the end of T3.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        CON,
    output logic        run,
    output logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout,
    output logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin,
    output logic        InPortin, OutPortin, Cin, CONin,
    output logic        read, wren,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
);

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
                           OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011,
                           OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
                           OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100,
                           OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111,
                           OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY,
        C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO
    } cls_t;

    typedef struct packed {
        logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout;
        logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin;
        logic InPortin, OutPortin, Cin, CONin;
        logic read, wren;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
    } cw_t;

    function automatic cls_t op_class(input logic [4:0] op);
        case (op)
            OP_LD:                    op_class = C_LD;
            OP_LDI:                   op_class = C_LDI;
            OP_ST:                    op_class = C_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:
                                      op_class = C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI: op_class = C_IMM;
            OP_MUL, OP_DIV:           op_class = C_MULDIV;
            OP_NEG, OP_NOT:           op_class = C_UNARY;
            OP_BR:                    op_class = C_BR;
            OP_JR:                    op_class = C_JR;
            OP_JAL:                   op_class = C_JAL;
            OP_IN:                    op_class = C_IN;
            OP_OUT:                   op_class = C_OUT;
            OP_MFHI:                  op_class = C_MFHI;
            OP_MFLO:                  op_class = C_MFLO;
            default:                  op_class = C_NOP;  // nop, halt and the unused codes
        endcase
    endfunction

    function automatic state_t last_step(input cls_t c);
        case (c)
            C_UNARY, C_JAL:        last_step = S_T5;
            C_ALU, C_IMM, C_LDI:   last_step = S_T6;
            C_MULDIV, C_BR:        last_step = S_T7;
            C_ST:                  last_step = S_T8;
            C_LD:                  last_step = S_T9;
            default:               last_step = S_T4;
        endcase
    endfunction

    function automatic cw_t alu_sel(input logic [4:0] op);
        alu_sel = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_sel.ADD = 1'b1;
            OP_SUB:          alu_sel.SUB = 1'b1;
            OP_SHR:          alu_sel.SHR = 1'b1;
            OP_SHL:          alu_sel.SHL = 1'b1;
            OP_ROR:          alu_sel.ROR = 1'b1;
            OP_ROL:          alu_sel.ROL = 1'b1;
            OP_AND, OP_ANDI: alu_sel.AND = 1'b1;
            OP_OR, OP_ORI:   alu_sel.OR  = 1'b1;
            OP_MUL:          alu_sel.MUL = 1'b1;
            OP_DIV:          alu_sel.DIV = 1'b1;
            OP_NEG:          alu_sel.NEG = 1'b1;
            OP_NOT:          alu_sel.NOT = 1'b1;
            default:         alu_sel = '0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    cls_t       cls;
    cw_t        cw;
    logic       unused_ir;

    assign cls       = op_class(op_q);
    assign unused_ir = ^ir[26:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                op_d = ir[31:27];
                if (ir[31:27] == OP_HALT)
                    state_d = S_HALT;
                else if (op_class(ir[31:27]) == C_NOP)
                    state_d = S_T0;
                else
                    state_d = S_T4;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = (state_q == last_step(cls)) ? S_T0 : state_t'(state_q + 4'd1);
        endcase
    end

    always_comb begin
        cw = '0;
        case (state_q)
            S_T0: begin cw.PCout = 1'b1; cw.MARin = 1'b1; cw.IncPC = 1'b1; cw.Zlowin = 1'b1; end
            S_T1: begin cw.Zlowout = 1'b1; cw.PCin = 1'b1; cw.read = 1'b1; end
            S_T2: begin cw.read = 1'b1; cw.MDRin = 1'b1; end
            S_T3: begin cw.MDRout = 1'b1; cw.IRin = 1'b1; end
            S_T4: case (cls)
                C_LD, C_LDI, C_ST: begin
                    cw.Grb = 1'b1; cw.Rout = 1'b1; cw.BAout = 1'b1; cw.Yin = 1'b1; cw.Cin = 1'b1;
                end
                C_ALU:    begin cw.Grb = 1'b1; cw.Rout = 1'b1; cw.Yin = 1'b1; end
                C_IMM:    begin cw.Grb = 1'b1; cw.Rout = 1'b1; cw.Yin = 1'b1; cw.Cin = 1'b1; end
                C_MULDIV: begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.Yin = 1'b1; end
                C_UNARY: begin
                    cw = alu_sel(op_q);
                    cw.Grb = 1'b1; cw.Rout = 1'b1; cw.Zlowin = 1'b1;
                end
                C_BR:   begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.CONin = 1'b1; cw.Cin = 1'b1; end
                C_JR:   begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.PCin = 1'b1; end
                C_JAL:  begin cw.PCout = 1'b1; cw.Grb = 1'b1; cw.Rin = 1'b1; end
                C_IN:   begin cw.InPortout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
                C_OUT:  begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.OutPortin = 1'b1; end
                C_MFHI: begin cw.HIout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
                C_MFLO: begin cw.LOout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
                default: cw = '0;
            endcase
            S_T5: case (cls)
                C_LD, C_LDI, C_ST: begin
                    cw.Cout = 1'b1; cw.ADD = 1'b1; cw.Zlowin = 1'b1; cw.Cin = 1'b1;
                end
                C_ALU: begin
                    cw = alu_sel(op_q);
                    cw.Grc = 1'b1; cw.Rout = 1'b1; cw.Zlowin = 1'b1;
                end
                C_IMM: begin
                    cw = alu_sel(op_q);
                    cw.Cin = 1'b1; cw.Cout = 1'b1; cw.Zlowin = 1'b1;
                end
                C_MULDIV: begin
                    cw = alu_sel(op_q);
                    cw.Grb = 1'b1; cw.Rout = 1'b1; cw.Zlowin = 1'b1; cw.Zhighin = 1'b1;
                end
                C_UNARY: begin cw.Zlowout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
                C_BR:    begin cw.PCout = 1'b1; cw.Yin = 1'b1; cw.Cin = 1'b1; end
                C_JAL:   begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.PCin = 1'b1; end
                default: cw = '0;
            endcase
            S_T6: case (cls)
                C_LDI, C_ALU, C_IMM: begin cw.Zlowout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
                C_LD, C_ST:          begin cw.Zlowout = 1'b1; cw.MARin = 1'b1; end
                C_MULDIV:            begin cw.Zlowout = 1'b1; cw.LOin = 1'b1; end
                C_BR:                begin cw.Cout = 1'b1; cw.ADD = 1'b1; cw.Zlowin = 1'b1; end
                default: cw = '0;
            endcase
            S_T7: case (cls)
                C_LD:     cw.read = 1'b1;
                C_ST:     begin cw.Gra = 1'b1; cw.Rout = 1'b1; cw.MDRin = 1'b1; end
                C_MULDIV: begin cw.Zhighout = 1'b1; cw.HIin = 1'b1; end
                // Branch target is always on the bus; only a true condition loads it.
                C_BR:     begin cw.Zlowout = 1'b1; cw.PCin = CON; end
                default: cw = '0;
            endcase
            S_T8: case (cls)
                C_LD:    begin cw.read = 1'b1; cw.MDRin = 1'b1; end
                C_ST:    cw.wren = 1'b1;
                default: cw = '0;
            endcase
            S_T9: if (cls == C_LD) begin cw.MDRout = 1'b1; cw.Gra = 1'b1; cw.Rin = 1'b1; end
            default: cw = '0;
        endcase
        if (clr) cw = '0;
    end

    assign run = clr || (state_q != S_HALT);

    assign {PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout,
            PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin,
            InPortin, OutPortin, Cin, CONin,
            read, wren,
            Gra, Grb, Grc, Rin, Rout, BAout,
            AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC} = cw;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each instruction pushes its expected per-cycle
// control words to a queue, which is then drained against the DUT one cycle at a time.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        CON;
    logic        run;
    logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout;
    logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin;
    logic        InPortin, OutPortin, Cin, CONin;
    logic        read, wren;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .CON(CON), .run(run),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .InPortin(InPortin),
        .OutPortin(OutPortin), .Cin(Cin), .CONin(CONin),
        .read(read), .wren(wren),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC)
    );

    typedef struct packed {
        logic run;
        logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout;
        logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin;
        logic InPortin, OutPortin, Cin, CONin;
        logic read, wren;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    total = 0;
    int    bad   = 0;

    function automatic exp_t w0();
        exp_t e;
        e = '0;
        e.run = 1'b1;
        return e;
    endfunction

    task automatic push(input exp_t e, input string tag);
        expq.push_back(e);
        tagq.push_back(tag);
    endtask

    // One expected word per cycle, checked mid-cycle; returns just after the next rising edge.
    task automatic drain();
        exp_t  e, obs;
        string t;
        while (expq.size() > 0) begin
            @(negedge clk);
            e = expq.pop_front();
            t = tagq.pop_front();
            obs = {run, PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout,
                   PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin,
                   InPortin, OutPortin, Cin, CONin, read, wren,
                   Gra, Grb, Grc, Rin, Rout, BAout,
                   AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC};
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [4:0] opc, input logic con, input string n);
        exp_t e;
        ir  = {opc, 27'($urandom())};
        CON = con;
        e = w0(); e.PCout = 1'b1; e.MARin = 1'b1; e.IncPC = 1'b1; e.Zlowin = 1'b1;
        push(e, {n, " T0"});
        e = w0(); e.Zlowout = 1'b1; e.PCin = 1'b1; e.read = 1'b1;  push(e, {n, " T1"});
        e = w0(); e.read = 1'b1; e.MDRin = 1'b1;                   push(e, {n, " T2"});
        e = w0(); e.MDRout = 1'b1; e.IRin = 1'b1;                  push(e, {n, " T3"});
    endtask

    task automatic do_alu(input logic [4:0] opc, input exp_t m, input string n);
        exp_t e;
        start(opc, 1'b0, n);
        e = w0(); e.Grb = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1;                push(e, {n, " T4"});
        e = exp_t'(w0() | m); e.Grc = 1'b1; e.Rout = 1'b1; e.Zlowin = 1'b1; push(e, {n, " T5"});
        e = w0(); e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1;             push(e, {n, " T6"});
        drain();
    endtask

    task automatic do_imm(input logic [4:0] opc, input exp_t m, input string n);
        exp_t e;
        start(opc, 1'b0, n);
        e = w0(); e.Grb = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1; e.Cin = 1'b1;  push(e, {n, " T4"});
        e = exp_t'(w0() | m); e.Cin = 1'b1; e.Cout = 1'b1; e.Zlowin = 1'b1; push(e, {n, " T5"});
        e = w0(); e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1;             push(e, {n, " T6"});
        drain();
    endtask

    task automatic do_unary(input logic [4:0] opc, input exp_t m, input string n);
        exp_t e;
        start(opc, 1'b0, n);
        e = exp_t'(w0() | m); e.Grb = 1'b1; e.Rout = 1'b1; e.Zlowin = 1'b1; push(e, {n, " T4"});
        e = w0(); e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1;             push(e, {n, " T5"});
        drain();
    endtask

    task automatic do_muldiv(input logic [4:0] opc, input exp_t m, input string n);
        exp_t e;
        start(opc, 1'b0, n);
        e = w0(); e.Gra = 1'b1; e.Rout = 1'b1; e.Yin = 1'b1; push(e, {n, " T4"});
        e = exp_t'(w0() | m); e.Grb = 1'b1; e.Rout = 1'b1; e.Zlowin = 1'b1; e.Zhighin = 1'b1;
        push(e, {n, " T5"});
        e = w0(); e.Zlowout = 1'b1; e.LOin = 1'b1;  push(e, {n, " T6"});
        e = w0(); e.Zhighout = 1'b1; e.HIin = 1'b1; push(e, {n, " T7"});
        drain();
    endtask

    // Effective-address prefix shared by ld/ldi/st; no drain so callers can extend it.
    task automatic push_ea(input logic [4:0] opc, input string n);
        exp_t e;
        start(opc, 1'b0, n);
        e = w0(); e.Grb = 1'b1; e.Rout = 1'b1; e.BAout = 1'b1; e.Yin = 1'b1; e.Cin = 1'b1;
        push(e, {n, " T4"});
        e = w0(); e.Cout = 1'b1; e.ADD = 1'b1; e.Zlowin = 1'b1; e.Cin = 1'b1;
        push(e, {n, " T5"});
    endtask

    task automatic do_br(input logic con, input string n);
        exp_t e;
        start(5'b10010, con, n);
        e = w0(); e.Gra = 1'b1; e.Rout = 1'b1; e.CONin = 1'b1; e.Cin = 1'b1; push(e, {n, " T4"});
        e = w0(); e.PCout = 1'b1; e.Yin = 1'b1; e.Cin = 1'b1;               push(e, {n, " T5"});
        e = w0(); e.Cout = 1'b1; e.ADD = 1'b1; e.Zlowin = 1'b1;             push(e, {n, " T6"});
        e = w0(); e.Zlowout = 1'b1; e.PCin = con;                           push(e, {n, " T7"});
        drain();
    endtask

    // Single-step execute (jr/in/out/mfhi/mflo): m holds the whole T4 word minus run.
    task automatic do_one(input logic [4:0] opc, input exp_t m, input string n);
        start(opc, 1'b0, n);
        push(exp_t'(w0() | m), {n, " T4"});
        drain();
    endtask

    initial begin
        exp_t e, m;
        clr = 1'b1;
        ir  = '0;
        CON = 1'b0;
        @(posedge clk);
        #1;
        push(w0(), "reset c0");
        push(w0(), "reset c1");
        drain();
        clr = 1'b0;

        m = '0; m.ADD = 1'b1; do_alu(5'b00011, m, "add");
        m = '0; m.SHL = 1'b1; do_alu(5'b00110, m, "shl");
        m = '0; m.OR  = 1'b1; do_imm(5'b01101, m, "ori");
        m = '0; m.NEG = 1'b1; do_unary(5'b10000, m, "neg");
        m = '0; m.MUL = 1'b1; do_muldiv(5'b01110, m, "mul");
        m = '0; m.DIV = 1'b1; do_muldiv(5'b01111, m, "div");

        push_ea(5'b00000, "ld");
        e = w0(); e.Zlowout = 1'b1; e.MARin = 1'b1;             push(e, "ld T6");
        e = w0(); e.read = 1'b1;                                push(e, "ld T7");
        e = w0(); e.read = 1'b1; e.MDRin = 1'b1;                push(e, "ld T8");
        e = w0(); e.MDRout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1;  push(e, "ld T9");
        drain();

        push_ea(5'b00001, "ldi");
        e = w0(); e.Zlowout = 1'b1; e.Gra = 1'b1; e.Rin = 1'b1; push(e, "ldi T6");
        drain();

        push_ea(5'b00010, "st");
        e = w0(); e.Zlowout = 1'b1; e.MARin = 1'b1;             push(e, "st T6");
        e = w0(); e.Gra = 1'b1; e.Rout = 1'b1; e.MDRin = 1'b1;  push(e, "st T7");
        e = w0(); e.wren = 1'b1;                                push(e, "st T8");
        drain();

        do_br(1'b1, "br taken");
        do_br(1'b0, "br not taken");

        m = '0; m.Gra = 1'b1; m.Rout = 1'b1; m.PCin = 1'b1;      do_one(5'b10011, m, "jr");
        start(5'b10100, 1'b0, "jal");
        e = w0(); e.PCout = 1'b1; e.Grb = 1'b1; e.Rin = 1'b1;    push(e, "jal T4");
        e = w0(); e.Gra = 1'b1; e.Rout = 1'b1; e.PCin = 1'b1;    push(e, "jal T5");
        drain();
        m = '0; m.InPortout = 1'b1; m.Gra = 1'b1; m.Rin = 1'b1;  do_one(5'b10101, m, "in");
        m = '0; m.Gra = 1'b1; m.Rout = 1'b1; m.OutPortin = 1'b1; do_one(5'b10110, m, "out");
        m = '0; m.HIout = 1'b1; m.Gra = 1'b1; m.Rin = 1'b1;      do_one(5'b10111, m, "mfhi");

        start(5'b11111, 1'b0, "nop11111"); drain();
        start(5'b11001, 1'b0, "nop");      drain();

        // clr while ld sits in T7: outputs drop at once, next cycle is a fresh fetch.
        push_ea(5'b00000, "ld cut");
        e = w0(); e.Zlowout = 1'b1; e.MARin = 1'b1; push(e, "ld cut T6");
        drain();
        clr = 1'b1;
        push(w0(), "clr mid-ld");
        drain();
        clr = 1'b0;
        m = '0; m.LOout = 1'b1; m.Gra = 1'b1; m.Rin = 1'b1; do_one(5'b11000, m, "mflo after clr");

        start(5'b11010, 1'b0, "halt");
        for (int i = 0; i < 20; i++) push('0, "halted");
        drain();
        clr = 1'b1;
        push(w0(), "clr in halt");
        drain();
        clr = 1'b0;
        m = '0; m.ADD = 1'b1; do_alu(5'b00011, m, "add after halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
